module_keypad_decoder: RTL

Row-side reader for the 4x4 matrix keypad scan. It consumes the column index produced by the 2-bit scan counter and drives that counter's `stop` input to pace it. It samples the four row lines, debounces press and release, and emits one registered key code with a single-cycle valid pulse per physical press. It sits between the keypad pins and downstream key-consuming logic.

---
 rtl/module_keypad_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/module_keypad_decoder.sv
// Row-side reader for a 4x4 matrix keypad: paces the column scan counter, debounces rows, emits key codes.
// Latency: 2-cycle row synchronizer; key_o/key_valid_o appear DEBOUNCE_CYCLES+1 cycles after the sampling cycle.
// Backpressure: none downstream; stop_o holds the external scan counter on the current column.
module module_keypad_decoder #(
    parameter int SCAN_DWELL      = 16,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] col_idx_i,
    input  logic [3:0] row_i,
    output logic       stop_o,
    output logic [3:0] key_o,
    output logic       key_valid_o
);

    localparam int DW = $clog2(SCAN_DWELL);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_s;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_nxt;
    logic [BW-1:0] r_db;
    logic [BW-1:0] w_db_nxt;
    logic [1:0]    r_row_lat;
    logic [1:0]    w_row_lat_nxt;
    logic [1:0]    r_col_lat;
    logic [1:0]    w_col_lat_nxt;
    logic [3:0]    r_key;
    logic [3:0]    w_key_nxt;
    logic          r_key_vld;
    logic          w_key_vld_nxt;
    logic          w_any_row;
    logic [1:0]    w_low_row;
    logic          w_lat_row_lvl;

    // Two-flop synchronizer for the asynchronous row pins; reset to "no key" so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
        end else begin
            r_row_meta <= row_i;
            r_row_s    <= r_row_meta;
        end
    end

    // Active-low rows: flag any active row and pick the lowest-numbered one.
    always_comb begin
        w_any_row = ~&r_row_s;
        w_low_row = 2'd3;
        if (!r_row_s[0]) begin
            w_low_row = 2'd0;
        end else if (!r_row_s[1]) begin
            w_low_row = 2'd1;
        end else if (!r_row_s[2]) begin
            w_low_row = 2'd2;
        end
    end

    // Once a key is latched only its own row is watched; other rows are ignored.
    assign w_lat_row_lvl = r_row_s[r_row_lat];

    // Next-state, counter updates and stop_o; stop_o releases the counter only on an empty dwell end.
    always_comb begin
        w_state_nxt   = r_state;
        w_dwell_nxt   = r_dwell;
        w_db_nxt      = r_db;
        w_row_lat_nxt = r_row_lat;
        w_col_lat_nxt = r_col_lat;
        w_key_nxt     = r_key;
        w_key_vld_nxt = 1'b0;
        stop_o        = 1'b1;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    if (w_any_row) begin
                        w_row_lat_nxt = w_low_row;
                        w_col_lat_nxt = col_idx_i;
                        w_db_nxt      = '0;
                        w_state_nxt   = ST_DEBOUNCE;
                    end else begin
                        stop_o      = 1'b0;
                        w_dwell_nxt = '0;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (w_lat_row_lvl) begin
                    // Bounce: counter was held, so the same column is sampled again.
                    w_state_nxt = ST_SCAN;
                    w_dwell_nxt = '0;
                end else if (r_db == DB_LAST) begin
                    w_state_nxt   = ST_HELD;
                    w_key_nxt     = {r_row_lat, r_col_lat};
                    w_key_vld_nxt = 1'b1;
                end else begin
                    w_db_nxt = r_db + BW'(1);
                end
            end
            ST_HELD: begin
                if (w_lat_row_lvl) begin
                    w_state_nxt = ST_RELEASE;
                    w_db_nxt    = '0;
                end
            end
            ST_RELEASE: begin
                if (!w_lat_row_lvl) begin
                    // Release bounce goes back to HELD silently: one pulse per physical press.
                    w_state_nxt = ST_HELD;
                end else if (r_db == DB_LAST) begin
                    w_state_nxt = ST_SCAN;
                    w_dwell_nxt = '0;
                end else begin
                    w_db_nxt = r_db + BW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_dwell   <= '0;
            r_db      <= '0;
            r_row_lat <= 2'd0;
            r_col_lat <= 2'd0;
            r_key     <= 4'h0;
            r_key_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dwell   <= w_dwell_nxt;
            r_db      <= w_db_nxt;
            r_row_lat <= w_row_lat_nxt;
            r_col_lat <= w_col_lat_nxt;
            r_key     <= w_key_nxt;
            r_key_vld <= w_key_vld_nxt;
        end
    end

    assign key_o       = r_key;
    assign key_valid_o = r_key_vld;

endmodule
